// File: rtl/combi_isa_mode_tracker.sv
// Decode-stage ISA selector with a hysteresis-filtered mode register and a
// registered D/E control bundle that supports stall, flush and forced mode loads.
module combi_isa_mode_tracker #(
  parameter int N_ISA     = 2,
  parameter int CTRL_W    = 16,
  parameter int THRESH    = 1,
  parameter int RESET_ISA = 0,
  localparam int MODE_W   = $clog2(N_ISA)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  input  logic                    stall,
  input  logic                    flush,
  input  logic [N_ISA-1:0]        isa_ok,
  input  logic [N_ISA*CTRL_W-1:0] ctrl_in,
  input  logic                    force_valid,
  input  logic [MODE_W-1:0]       force_mode,
  output logic [MODE_W-1:0]       mode,
  output logic                    out_valid,
  output logic [MODE_W-1:0]       out_isa,
  output logic [CTRL_W-1:0]       ctrl_out,
  output logic                    illegal,
  output logic                    switch_pulse
);

  localparam int                CNT_W      = $clog2(THRESH + 1);
  localparam logic [CNT_W-1:0]  THRESH_C   = CNT_W'(THRESH);
  localparam logic [MODE_W-1:0] RESET_MODE = MODE_W'(RESET_ISA);

  logic [MODE_W-1:0] mode_q, mode_d;
  logic [MODE_W-1:0] cand_q, cand_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [MODE_W-1:0] out_isa_q, out_isa_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              illegal_q, illegal_d;
  logic              pulse_q, pulse_d;

  logic [N_ISA-1:0]  other;
  int                n_other;
  logic [MODE_W-1:0] low_idx;
  logic [MODE_W-1:0] sel;
  logic              ill;
  logic [CNT_W-1:0]  cnt_inc;
  logic [CTRL_W-1:0] slice;

  // Legal ISAs other than the current mode, their count and the lowest index.
  always_comb begin
    other          = isa_ok;
    other[mode_q]  = 1'b0;
    n_other        = 0;
    low_idx        = '0;
    for (int i = N_ISA - 1; i >= 0; i--) begin
      if (other[i]) begin
        n_other = n_other + 1;
        low_idx = MODE_W'(i);
      end
    end
  end

  always_comb begin
    mode_d      = mode_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_isa_d   = out_isa_q;
    ctrl_d      = ctrl_q;
    illegal_d   = illegal_q;
    pulse_d     = pulse_q;
    sel         = mode_q;
    ill         = 1'b0;
    cnt_inc     = '0;
    slice       = '0;

    if (flush) begin
      out_valid_d = 1'b0;
      ctrl_d      = '0;
      illegal_d   = 1'b0;
      pulse_d     = 1'b0;
    end else if (!stall) begin
      pulse_d = 1'b0;
      if (!in_valid) begin
        out_valid_d = 1'b0;
        ctrl_d      = '0;
        illegal_d   = 1'b0;
      end else begin
        if (isa_ok[mode_q]) begin
          sel   = mode_q;
          cnt_d = '0;
        end else if (n_other == 1) begin
          sel = low_idx;
          if (cand_q == low_idx && cnt_q < THRESH_C) begin
            cnt_inc = cnt_q + CNT_W'(1);
          end else begin
            cand_d  = low_idx;
            cnt_inc = CNT_W'(1);
          end
          if (cnt_inc == THRESH_C) begin
            mode_d  = low_idx;
            cnt_d   = '0;
            pulse_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end else if (n_other > 1) begin
          sel   = low_idx;
          cnt_d = '0;
        end else begin
          sel   = mode_q;
          ill   = 1'b1;
          cnt_d = '0;
        end
        for (int i = 0; i < N_ISA; i++) begin
          if (sel == MODE_W'(i)) slice = ctrl_in[i*CTRL_W +: CTRL_W];
        end
        out_valid_d = 1'b1;
        out_isa_d   = sel;
        illegal_d   = ill;
        ctrl_d      = ill ? '0 : slice;
      end
    end

    // Architectural mode writes override hysteresis, even while stalled.
    if (force_valid && int'(force_mode) < N_ISA) begin
      mode_d  = force_mode;
      cnt_d   = '0;
      cand_d  = '0;
      pulse_d = (force_mode != mode_q);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q      <= RESET_MODE;
      cand_q      <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_isa_q   <= RESET_MODE;
      ctrl_q      <= '0;
      illegal_q   <= 1'b0;
      pulse_q     <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_isa_q   <= out_isa_d;
      ctrl_q      <= ctrl_d;
      illegal_q   <= illegal_d;
      pulse_q     <= pulse_d;
    end
  end

  assign mode         = mode_q;
  assign out_valid    = out_valid_q;
  assign out_isa      = out_isa_q;
  assign ctrl_out     = ctrl_q;
  assign illegal      = illegal_q;
  assign switch_pulse = pulse_q;

endmodule

// File: doc/combi_isa_mode_tracker.md
Name: combi_isa_mode_tracker

Overview:
- Decode-stage mode tracker and pipeline register for a multi-ISA core. Generalises the two-ISA ARM/RISC-V combi decode selection to N_ISA instruction sets.
- Per-ISA sub-decoders supply a legality flag and a packed control bundle for each ISA. This block picks the decoding ISA for each instruction.
- It holds a persistent mode register with hysteresis, so the mode switches only after THRESH consecutive instructions that are legal in exactly one other ISA.
- It registers the selected control bundle into the D/E boundary with stall and flush handling.

Parameters:
- N_ISA, 2, number of instruction sets (>=2).
- CTRL_W, 16, width of one ISA's control bundle.
- THRESH, 1, consecutive exclusive-legal instructions needed to commit a mode switch (>=1; 1 = switch immediately).
- RESET_ISA, 0, mode after reset (< N_ISA).
- MODE_W, $clog2(N_ISA), derived; not overridable.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  decode slot holds a real instruction (0 = bubble).
- stall  in  1  hold all state and outputs.
- flush  in  1  kill the decode slot.
- isa_ok  in  N_ISA  bit i = instruction legal under ISA i.
- ctrl_in  in  N_ISA*CTRL_W  bundle for ISA i at [i*CTRL_W +: CTRL_W].
- force_valid  in  1  architectural mode change (BX/CSR write).
- force_mode  in  MODE_W  target mode for force_valid.
- mode  out  MODE_W  committed ISA mode.
- out_valid  out  1  registered instruction valid.
- out_isa  out  MODE_W  ISA used to decode the registered instruction.
- ctrl_out  out  CTRL_W  registered control bundle.
- illegal  out  1  registered instruction legal in no ISA.
- switch_pulse  out  1  one-cycle pulse when mode changed on the last edge.

Behaviour:
- Reset (async, reset_n=0):
  - mode=RESET_ISA; out_valid=0, out_isa=RESET_ISA, ctrl_out=0, illegal=0, switch_pulse=0.
  - Candidate register = 0, counter = 0. The counter is $clog2(THRESH+1) bits.
  - Reset asserted mid-operation discards any partial count.
- Accept = in_valid & ~stall & ~flush. Latency: one cycle from accept to outputs.
- Selection on accept, evaluated in this priority order:
  1. isa_ok[mode]=1: sel=mode; counter cleared.
  2. Exactly one bit j != mode set: sel=j.
     - If candidate==j and counter<THRESH: counter+1. Otherwise candidate=j, counter=1.
     - If the new counter value equals THRESH: mode<=j, counter cleared, switch_pulse=1.
  3. Two or more bits set, none equal to mode: sel = lowest set index; counter cleared; no switch.
  4. isa_ok=0: illegal=1, ctrl_out=0, out_isa=mode; counter cleared.
- Outputs on accept: out_valid=1, out_isa=sel, ctrl_out=ctrl_in slice sel (0 if illegal), illegal as above.
- force_valid:
  - Loads mode<=force_mode and clears counter and candidate.
  - Acts whenever force_valid=1, regardless of stall, flush or in_valid.
  - Overrides any hysteresis switch on the same edge; the coincident instruction is still decoded per the selection rules above.
  - switch_pulse=1 only if force_mode != old mode.
  - force_mode >= N_ISA is ignored.
- flush (wins over stall): out_valid=0, ctrl_out=0, illegal=0. Mode, candidate and counter hold.
- stall without flush: every register holds, including switch_pulse. Only force_valid still acts.
- Bubble (in_valid=0, no stall, no flush): out_valid=0, ctrl_out=0, illegal=0. Mode, candidate and counter hold.
- switch_pulse is 0 on every edge without a mode change, except when held by stall.
- The counter never exceeds THRESH.

Test Plan:
- Reset: assert reset_n=0 mid-stream -> immediately mode=0, out_valid=0, ctrl_out=0, switch_pulse=0.
- N_ISA=2, THRESH=3, mode 0, three accepts with isa_ok=2'b10, ctrl_in[31:16]=16'hA5A5 -> out_isa=1 and ctrl_out=A5A5 each cycle; mode=1 and switch_pulse=1 only after the third.
- THRESH=3: two accepts with isa_ok=10, one with 11, two with 10 -> mode stays 0, switch_pulse never 1.
- isa_ok=00 with in_valid=1 -> out_valid=1, illegal=1, ctrl_out=0, mode unchanged. Next: flush=1 and stall=1 together -> out_valid=0.
- Stall=1 for 4 cycles during a pending count (counter=2) -> all outputs frozen. After release, one isa_ok=10 accept -> switch.
- N_ISA=3, mode 0, isa_ok=3'b110 -> out_isa=1, no count. Separately, force_valid with force_mode=2 on the same edge as the THRESH-reaching accept -> mode=2, switch_pulse=1.
